csr_trap_file: RTL and testbench
================================

# csr_trap_file

Machine-mode CSR register file and trap sequencer sitting in the writeback stage, directly downstream of the decode-stage CSR behaviour logic. Supplies the current CSR value combinationally to decode and commits CSR writes from WB. Takes ecall/mret/external-interrupt events from EX, updates mepc/mcause/mstatus, and issues a registered one-cycle PC redirect plus pipeline flush.

## Interface
- XLEN, 2'd2, width code; W = 1<<(XLEN+4) (2'd1 → 32, 2'd2 → 64)
- HART_ID, 0, value returned by mhartid
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_csr_addr_d  in  12  decode-stage CSR read address
- o_csr_d  out  W  combinational read data for i_csr_addr_d; 0 for unimplemented addresses
- i_csr_reg_write_w  in  1  WB CSR write enable
- i_csr_rd_w  in  12  WB CSR write address
- i_new_csr_w  in  W  WB CSR write data
- i_ecall_e  in  1  ecall in EX
- i_mret_e  in  1  mret in EX
- i_pc_e  in  W  PC of the EX instruction
- i_ext_irq  in  1  level external interrupt; mirrored into mip.MEIP (bit 11)
- i_retire_w  in  1  one instruction retired this cycle
- o_redirect  out  1  PC redirect pulse
- o_redirect_pc  out  W  redirect target
- o_flush  out  1  flush IF/ID/EX; equal to o_redirect

## Operation
- Implemented CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, MPP bits 12:11 hardwired 2'b11, all other bits read 0), mie 0x304 (only bit 11 writable), mtvec 0x305 (bits 1:0 forced 0, direct mode only), mscratch 0x340, mepc 0x341 (bits 1:0 forced 0), mcause 0x342, mip 0x344 (read-only), mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (read-only).
- Writes to read-only or unimplemented addresses are ignored.
- mcycle increments every cycle. minstret increments when i_retire_w=1. A WB write to either counter takes precedence over that cycle's increment. Both wrap modulo 2^W.
- FSM states:
  - RUN: accepts events, in priority order irq > ecall > mret.
  - REDIR: one cycle; asserts the redirect, accepts no events, then returns to RUN.
- Interrupt taken when mstatus.MIE & mie[11] & i_ext_irq:
  - mepc ← i_pc_e
  - mcause ← {1, 0…, 11}
  - MPIE ← MIE, MIE ← 0
  - target ← mtvec
- ecall:
  - mepc ← i_pc_e
  - mcause ← 11
  - MPIE ← MIE, MIE ← 0
  - target ← mtvec
- mret:
  - MIE ← MPIE, MPIE ← 1
  - target ← mepc
- A trap-side update wins over a same-cycle WB write to mepc, mcause or mstatus. A WB write to any other CSR in that cycle still commits.
- The bypass read path (o_csr_d) does not forward same-cycle WB write data; the value appears the next cycle.

## Timing
- Reset values:
  - all CSRs 0, except mstatus.MPP = 2'b11 and mhartid = HART_ID
  - FSM in RUN
  - o_redirect = 0, o_redirect_pc = 0, o_flush = 0
- CSR write latency: 1 cycle (visible on o_csr_d the cycle after the i_csr_reg_write_w edge).
- Event latency: an event sampled at edge N produces o_redirect = o_flush = 1 and a valid o_redirect_pc for exactly the cycle after edge N.
  - o_redirect_pc is computed from the mtvec/mepc values before edge N.
  - o_redirect_pc holds its value while o_redirect = 0.
- In REDIR, i_ecall_e, i_mret_e and interrupt take are ignored (the flushed instruction); a still-pending irq is taken on the following RUN cycle.
- Simultaneous ecall and mret: ecall wins. Simultaneous irq and ecall: irq wins and the ecall's side effects are dropped.
- Reset asserted mid-REDIR: outputs drop to 0 asynchronously; no partial CSR update survives.

## Test plan
- Reset, then write mtvec=0x100 via WB; next cycle o_csr_d(0x305) = 0x100. Write 0x103 → reads 0x100.
- Set mstatus.MIE=1, ecall with i_pc_e=0x40:
  - one cycle later o_redirect=1 and o_redirect_pc=0x100 for exactly 1 cycle
  - mepc=0x40, mcause=11, mstatus=0x1880
- mret after the ecall: redirect to 0x40; mstatus.MIE=1, MPIE=1.
- MIE=1, mie=0x800, raise i_ext_irq together with an ecall at pc 0x80:
  - mcause = MSB|11, mepc=0x80
  - ecall ignored; the irq is not retaken while MIE=0
- WB write mcycle=5 in the same cycle as increment: reads 5 next cycle, then 6; minstret counts only i_retire_w pulses. Write mhartid → unchanged.
- Assert i_rst_n low during the REDIR cycle: o_redirect falls immediately; all CSRs return to reset values.

Source files
------------

// File: rtl/csr_trap_file.sv
// Machine-mode CSR file with a two-state trap sequencer (RUN/REDIR).
// Reads are combinational for decode; writes, traps and counters commit on the clock edge.
module csr_trap_file #(
  parameter logic [1:0]  XLEN    = 2'd2,
  parameter int unsigned HART_ID = 0,
  localparam int         W       = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [11:0]  i_csr_addr_d,
  output logic [W-1:0] o_csr_d,
  input  logic         i_csr_reg_write_w,
  input  logic [11:0]  i_csr_rd_w,
  input  logic [W-1:0] i_new_csr_w,
  input  logic         i_ecall_e,
  input  logic         i_mret_e,
  input  logic [W-1:0] i_pc_e,
  input  logic         i_ext_irq,
  input  logic         i_retire_w,
  output logic         o_redirect,
  output logic [W-1:0] o_redirect_pc,
  output logic         o_flush
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [W-1:0] ECALL_CAUSE = W'(11);
  localparam logic [W-1:0] IRQ_CAUSE   = {1'b1, (W-1)'(11)};

  typedef enum logic {RUN, REDIR} state_t;

  state_t state, next_state;

  logic         status_mie;
  logic         status_mpie;
  logic         mie_meie;
  logic [W-1:0] mtvec;
  logic [W-1:0] mscratch;
  logic [W-1:0] mepc;
  logic [W-1:0] mcause;
  logic [W-1:0] mcycle;
  logic [W-1:0] minstret;
  logic [W-1:0] redirect_pc;

  logic         irq_take;
  logic         ecall_take;
  logic         mret_take;
  logic         trap_take;
  logic         event_take;

  logic [W-1:0] mstatus_val;
  logic [W-1:0] mie_val;
  logic [W-1:0] mip_val;
  logic [W-1:0] csr_rdata;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic wr_mcycle, wr_minstret;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Events are only accepted in RUN; the REDIR cycle holds the instruction being flushed.
  always_comb begin
    irq_take   = 1'b0;
    ecall_take = 1'b0;
    mret_take  = 1'b0;
    next_state = RUN;
    if (state == RUN) begin
      irq_take   = status_mie & mie_meie & i_ext_irq;
      ecall_take = i_ecall_e & ~irq_take;
      mret_take  = i_mret_e & ~irq_take & ~i_ecall_e;
      if (irq_take | ecall_take | mret_take) begin
        next_state = REDIR;
      end
    end
  end

  assign trap_take  = irq_take | ecall_take;
  assign event_take = trap_take | mret_take;

  assign o_redirect    = (state == REDIR);
  assign o_flush       = o_redirect;
  assign o_redirect_pc = redirect_pc;

  assign wr_mstatus  = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MSTATUS);
  assign wr_mie      = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MIE);
  assign wr_mtvec    = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MTVEC);
  assign wr_mscratch = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MSCRATCH);
  assign wr_mepc     = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MEPC);
  assign wr_mcause   = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MCAUSE);
  assign wr_mcycle   = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MCYCLE);
  assign wr_minstret = i_csr_reg_write_w && (i_csr_rd_w == ADDR_MINSTRET);

  // Trap-side updates override any same-cycle WB write to the fields they touch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_meie    <= 1'b0;
      mtvec       <= '0;
      mscratch    <= '0;
      mepc        <= '0;
      mcause      <= '0;
      mcycle      <= '0;
      minstret    <= '0;
      redirect_pc <= '0;
    end else begin
      if (trap_take) begin
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else if (mret_take) begin
        status_mie  <= status_mpie;
        status_mpie <= 1'b1;
      end else if (wr_mstatus) begin
        status_mie  <= i_new_csr_w[3];
        status_mpie <= i_new_csr_w[7];
      end

      if (trap_take) begin
        mepc   <= {i_pc_e[W-1:2], 2'b00};
        mcause <= irq_take ? IRQ_CAUSE : ECALL_CAUSE;
      end else begin
        if (wr_mepc) begin
          mepc <= {i_new_csr_w[W-1:2], 2'b00};
        end
        if (wr_mcause) begin
          mcause <= i_new_csr_w;
        end
      end

      if (wr_mie) begin
        mie_meie <= i_new_csr_w[11];
      end
      if (wr_mtvec) begin
        mtvec <= {i_new_csr_w[W-1:2], 2'b00};
      end
      if (wr_mscratch) begin
        mscratch <= i_new_csr_w;
      end

      mcycle   <= wr_mcycle ? i_new_csr_w : mcycle + 1'b1;
      if (wr_minstret) begin
        minstret <= i_new_csr_w;
      end else if (i_retire_w) begin
        minstret <= minstret + 1'b1;
      end

      // Target uses the pre-edge mtvec/mepc, so this cycle's writes cannot affect it.
      if (event_take) begin
        redirect_pc <= trap_take ? mtvec : mepc;
      end
    end
  end

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = status_mpie;
    mstatus_val[3]     = status_mie;
    mie_val            = '0;
    mie_val[11]        = mie_meie;
    mip_val            = '0;
    mip_val[11]        = i_ext_irq;
  end

  always_comb begin
    csr_rdata = '0;
    case (i_csr_addr_d)
      ADDR_MSTATUS:  csr_rdata = mstatus_val;
      ADDR_MIE:      csr_rdata = mie_val;
      ADDR_MTVEC:    csr_rdata = mtvec;
      ADDR_MSCRATCH: csr_rdata = mscratch;
      ADDR_MEPC:     csr_rdata = mepc;
      ADDR_MCAUSE:   csr_rdata = mcause;
      ADDR_MIP:      csr_rdata = mip_val;
      ADDR_MCYCLE:   csr_rdata = mcycle;
      ADDR_MINSTRET: csr_rdata = minstret;
      ADDR_MHARTID:  csr_rdata = W'(HART_ID);
      default:       csr_rdata = '0;
    endcase
  end

  assign o_csr_d = csr_rdata;

endmodule

// File: tb/tb_csr_trap_file.sv
// Directed bench for csr_trap_file: CSR access, ecall/mret/irq sequencing, counters and reset.
`timescale 1ns/1ps
module tb_csr_trap_file;

  logic        i_clk;
  logic        i_rst_n;
  logic [11:0] i_csr_addr_d;
  logic [63:0] o_csr_d;
  logic        i_csr_reg_write_w;
  logic [11:0] i_csr_rd_w;
  logic [63:0] i_new_csr_w;
  logic        i_ecall_e;
  logic        i_mret_e;
  logic [63:0] i_pc_e;
  logic        i_ext_irq;
  logic        i_retire_w;
  logic        o_redirect;
  logic [63:0] o_redirect_pc;
  logic        o_flush;

  int compareCount;
  int mismatchCount;

  csr_trap_file #(.XLEN(2'd2), .HART_ID(3)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_csr_addr_d      (i_csr_addr_d),
    .o_csr_d           (o_csr_d),
    .i_csr_reg_write_w (i_csr_reg_write_w),
    .i_csr_rd_w        (i_csr_rd_w),
    .i_new_csr_w       (i_new_csr_w),
    .i_ecall_e         (i_ecall_e),
    .i_mret_e          (i_mret_e),
    .i_pc_e            (i_pc_e),
    .i_ext_irq         (i_ext_irq),
    .i_retire_w        (i_retire_w),
    .o_redirect        (o_redirect),
    .o_redirect_pc     (o_redirect_pc),
    .o_flush           (o_flush)
  );

  // 20 ns clock; stimulus changes and sampling happen just after the falling edge
  initial begin
    i_clk = 1'b0;
    forever #10 i_clk = ~i_clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of WB write and EX event inputs
  task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [63:0] data,
                               input logic ecall, input logic mret, input logic irq,
                               input logic retire, input logic [63:0] pc);
    i_csr_reg_write_w = wr;
    i_csr_rd_w        = addr;
    i_new_csr_w       = data;
    i_ecall_e         = ecall;
    i_mret_e          = mret;
    i_ext_irq         = irq;
    i_retire_w        = retire;
    i_pc_e            = pc;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Combinational read through the decode-side port
  task automatic checkCsr(input string tag, input logic [11:0] addr, input logic [63:0] expected);
    i_csr_addr_d = addr;
    #1;
    checkOutput(tag, o_csr_d, expected);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    i_rst_n       = 1'b0;
    i_csr_addr_d  = 12'h0;
    idle();
    @(negedge i_clk);
    @(negedge i_clk);

    checkOutput("rst_redirect", {63'h0, o_redirect}, 64'h0);
    checkOutput("rst_redirect_pc", o_redirect_pc, 64'h0);
    checkOutput("rst_flush", {63'h0, o_flush}, 64'h0);
    checkCsr("rst_mstatus", 12'h300, 64'h1800);
    checkCsr("rst_mhartid", 12'hF14, 64'h3);
    checkCsr("rst_mtvec", 12'h305, 64'h0);

    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // mtvec write, no same-cycle forwarding, low bits forced to zero
    applyStimulus(1'b1, 12'h305, 64'h100, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    checkCsr("mtvec_no_forward", 12'h305, 64'h0);
    tick();
    idle();
    checkCsr("mtvec_write", 12'h305, 64'h100);
    applyStimulus(1'b1, 12'h305, 64'h103, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    idle();
    checkCsr("mtvec_align", 12'h305, 64'h100);

    applyStimulus(1'b1, 12'h300, 64'h8, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    idle();
    checkCsr("mstatus_set_mie", 12'h300, 64'h1808);

    // ecall at 0x40 with a concurrent mscratch write that must still commit
    applyStimulus(1'b1, 12'h340, 64'h55, 1'b1, 1'b0, 1'b0, 1'b0, 64'h40);
    #1;
    checkOutput("pre_ecall_redirect", {63'h0, o_redirect}, 64'h0);
    tick();
    checkOutput("ecall_redirect", {63'h0, o_redirect}, 64'h1);
    checkOutput("ecall_flush", {63'h0, o_flush}, 64'h1);
    checkOutput("ecall_target", o_redirect_pc, 64'h100);
    // ecall still asserted during REDIR must be ignored
    applyStimulus(1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h44);
    checkCsr("ecall_mepc", 12'h341, 64'h40);
    checkCsr("ecall_mcause", 12'h342, 64'hB);
    checkCsr("ecall_mstatus", 12'h300, 64'h1880);
    checkCsr("ecall_mscratch", 12'h340, 64'h55);
    tick();
    idle();
    checkOutput("redirect_one_cycle", {63'h0, o_redirect}, 64'h0);
    checkOutput("redirect_pc_hold", o_redirect_pc, 64'h100);
    checkCsr("redir_ignores_ecall", 12'h341, 64'h40);

    // mret back to 0x40
    applyStimulus(1'b0, 12'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    idle();
    checkOutput("mret_redirect", {63'h0, o_redirect}, 64'h1);
    checkOutput("mret_target", o_redirect_pc, 64'h40);
    checkCsr("mret_mstatus", 12'h300, 64'h1888);
    tick();

    applyStimulus(1'b1, 12'h304, 64'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    idle();
    checkCsr("mie_mask", 12'h304, 64'h800);

    // irq beats ecall; the WB mepc write in the same cycle loses to the trap
    applyStimulus(1'b1, 12'h341, 64'h999, 1'b1, 1'b0, 1'b1, 1'b0, 64'h80);
    tick();
    applyStimulus(1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    checkOutput("irq_redirect", {63'h0, o_redirect}, 64'h1);
    checkOutput("irq_target", o_redirect_pc, 64'h100);
    checkCsr("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
    checkCsr("irq_mepc", 12'h341, 64'h80);
    checkCsr("irq_mstatus", 12'h300, 64'h1880);
    checkCsr("irq_mip", 12'h344, 64'h800);
    tick();
    checkOutput("irq_not_retaken", {63'h0, o_redirect}, 64'h0);
    tick();
    checkOutput("irq_masked", {63'h0, o_redirect}, 64'h0);
    idle();
    checkCsr("mip_clear", 12'h344, 64'h0);

    // counters and read-only registers
    applyStimulus(1'b1, 12'hB00, 64'h5, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    idle();
    checkCsr("mcycle_write", 12'hB00, 64'h5);
    tick();
    checkCsr("mcycle_inc", 12'hB00, 64'h6);

    applyStimulus(1'b1, 12'hB02, 64'hA, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    tick();
    idle();
    checkCsr("minstret_write_wins", 12'hB02, 64'hA);
    applyStimulus(1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    tick();
    idle();
    tick();
    applyStimulus(1'b0, 12'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    tick();
    idle();
    tick();
    checkCsr("minstret_count", 12'hB02, 64'hC);

    applyStimulus(1'b1, 12'hF14, 64'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    idle();
    checkCsr("mhartid_readonly", 12'hF14, 64'h3);
    applyStimulus(1'b1, 12'h344, 64'h800, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    idle();
    checkCsr("mip_readonly", 12'h344, 64'h0);

    // reset asserted during the REDIR cycle
    applyStimulus(1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h60);
    tick();
    idle();
    checkOutput("pre_reset_redirect", {63'h0, o_redirect}, 64'h1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("reset_redirect", {63'h0, o_redirect}, 64'h0);
    checkOutput("reset_flush", {63'h0, o_flush}, 64'h0);
    checkOutput("reset_redirect_pc", o_redirect_pc, 64'h0);
    checkCsr("reset_mtvec", 12'h305, 64'h0);
    checkCsr("reset_mepc", 12'h341, 64'h0);
    checkCsr("reset_mcause", 12'h342, 64'h0);
    checkCsr("reset_mstatus", 12'h300, 64'h1800);
    checkCsr("reset_mscratch", 12'h340, 64'h0);
    checkCsr("reset_mie", 12'h304, 64'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // simultaneous ecall and mret: ecall wins
    applyStimulus(1'b1, 12'h305, 64'h200, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b0, 12'h0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h20);
    tick();
    idle();
    checkOutput("ecall_over_mret_redirect", {63'h0, o_redirect}, 64'h1);
    checkOutput("ecall_over_mret_target", o_redirect_pc, 64'h200);
    checkCsr("ecall_over_mret_mcause", 12'h342, 64'hB);
    checkCsr("ecall_over_mret_mepc", 12'h341, 64'h20);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
